// File: rtl/sbox_share_sched.sv
// Issue scheduler for the shared masked S-box pipeline.
// Arbitrates the state datapath against the key schedule, gates every issue
// on fresh randomness, and carries a {valid, side} tag alongside each word so
// the result strobe returns to the requester that issued it, LAT cycles later.
module sbox_share_sched #(
    parameter int LAT      = 4,
    parameter bit KEY_PRIO = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       dat_valid,
    output logic                       dat_ready,
    input  logic                       key_valid,
    output logic                       key_ready,
    input  logic                       rnd_valid,
    output logic                       rnd_ready,
    output logic                       sb_in_sel,
    output logic                       sb_issue,
    output logic                       dat_res_valid,
    output logic                       key_res_valid,
    output logic                       busy,
    output logic [$clog2(LAT+1)-1:0]   inflight
);
    localparam int CW = $clog2(LAT+1);

    // side: 0 = state word, 1 = key word
    typedef struct packed {
        logic vld;
        logic side;
    } tag_t;

    tag_t [LAT-1:0] tag_q;
    logic [CW-1:0]  cnt_q;
    logic           rr_q;     // round-robin pointer, 0 names the state side
    logic           sel_q;    // last granted side, held while idle
    logic           contested;
    logic           grant;
    logic           gside;
    logic           retire;

    // Grant decision; rst_n is folded in so the combinational readies are
    // already low while reset is held, not only after the next edge.
    always_comb begin
        contested = dat_valid & key_valid;
        grant     = rst_n & rnd_valid & ~flush & (dat_valid | key_valid);
        gside     = key_valid;
        if (contested)
            gside = KEY_PRIO ? 1'b1 : rr_q;
    end

    assign retire        = tag_q[LAT-1].vld;
    assign dat_ready     = grant & ~gside;
    assign key_ready     = grant & gside;
    assign rnd_ready     = grant;
    assign sb_issue      = grant;
    assign sb_in_sel     = grant ? gside : sel_q;
    assign dat_res_valid = tag_q[LAT-1].vld & ~tag_q[LAT-1].side;
    assign key_res_valid = tag_q[LAT-1].vld &  tag_q[LAT-1].side;
    assign inflight      = cnt_q;
    assign busy          = rst_n & ((cnt_q != '0) | dat_valid | key_valid);

    // Arbitration state, tag shift register and in-flight counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
            cnt_q <= '0;
            rr_q  <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            if (grant)
                sel_q <= gside;
            // only contested grants move the pointer; flush never grants
            if (grant && contested && !KEY_PRIO)
                rr_q <= ~rr_q;
            if (flush) begin
                tag_q <= '0;
                cnt_q <= '0;
            end else begin
                for (int i = 1; i < LAT; i++)
                    tag_q[i] <= tag_q[i-1];
                tag_q[0] <= tag_t'({grant, sb_in_sel});
                cnt_q    <= cnt_q + CW'(grant) - CW'(retire);
            end
        end
    end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Scheduler for the single shared 32-bit masked S-box pipeline: four byte lanes, HPC2 gadgets feeding the final linear output layer.
- Arbitrates issue slots between the round-state datapath (SubBytes) and the key schedule (SubWord).
- Issues a slot only when fresh randomness is valid, and tracks each in-flight word through the fixed pipeline latency so the result-valid strobe reaches the requester that issued it.
- Control only; the d-share data muxing is driven by its sel outputs.

Parameters:
- LAT, 4, S-box pipeline latency in cycles from issue to result (≥1).
- KEY_PRIO, 0, 1 = key requester always wins ties; 0 = round-robin.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort: kill all in-flight tags
- dat_valid  in  1  state datapath requests one S-box word
- dat_ready  out  1  state word accepted this cycle
- key_valid  in  1  key schedule requests one S-box word
- key_ready  out  1  key word accepted this cycle
- rnd_valid  in  1  PRNG has a fresh randomness word for one issue
- rnd_ready  out  1  randomness word consumed this cycle
- sb_in_sel  out  1  input mux select: 0 = state word, 1 = key word
- sb_issue  out  1  valid word entering S-box pipeline this cycle
- dat_res_valid  out  1  S-box output is the state result issued LAT cycles earlier
- key_res_valid  out  1  S-box output is the key result issued LAT cycles earlier
- busy  out  1  any tag in flight or request pending
- inflight  out  $clog2(LAT+1)  count of words in pipeline

Behaviour:
- Reset (async, rst_n=0): all tag pipeline stages are invalid, the round-robin pointer points to data, and every output is 0. This includes dat_ready, key_ready, rnd_ready, sb_in_sel, sb_issue, both res_valid strobes, busy and inflight.
- Issue rule (combinational, each cycle):
  - grant allowed only if rnd_valid=1 and flush=0; otherwise no readies assert.
  - only one requester is valid → grant it.
  - both valid, KEY_PRIO=1 → grant key.
  - both valid, KEY_PRIO=0 → grant the side the RR pointer names; the pointer flips to the other side after each contested grant. Uncontested grants do not move it.
- On a grant: the granted ready=1, rnd_ready=1, sb_issue=1, and sb_in_sel = granted side. With no grant, sb_in_sel holds its last value and sb_issue=0.
- Tag pipeline: LAT-stage shift register of {valid, side}, registered. Stage 0 loads {sb_issue, sb_in_sel}. The last stage drives dat_res_valid (valid & side=0) and key_res_valid (valid & side=1).
- Issue-to-result latency is exactly LAT cycles. Throughput is one word per cycle; back-to-back issues are legal with no bubbles.
- No output backpressure: consumers must accept the result in the strobe cycle.
- inflight = number of valid tag stages, registered. Issue and retire in the same cycle leave it unchanged.
- busy = (inflight≠0) | dat_valid | key_valid.
- flush=1: all tag stages are cleared on the next edge, no grant that cycle, and res_valid strobes are 0 from the next cycle. The RR pointer is not changed.
- rnd_valid drop mid-stream: issue stalls and in-flight words still retire on schedule.
- Requester valids may drop without a grant; no state is kept for unaccepted requests.
- rst_n asserted mid-operation: immediate clear, identical to reset state, no result strobes afterwards.

Test Plan:
- Reset, then dat_valid=1 with rnd_valid=1 at cycle 0 → dat_ready=1, sb_in_sel=0, sb_issue=1 at cycle 0; dat_res_valid=1 exactly at cycle LAT=4; inflight reads 1 from cycle 1 through cycle 4, then 0.
- KEY_PRIO=0, both valid continuously for 6 cycles → grants alternate D,K,D,K,D,K; res strobes replay the same pattern 4 cycles later; inflight saturates at 4.
- KEY_PRIO=1, both valid for 3 cycles → key granted all 3 cycles and dat_ready stays 0; then key_valid=0 → data is granted the next cycle.
- Both valid with rnd_valid toggling 1,0,1,0 → issues only in the rnd_valid=1 cycles, rnd_ready equals sb_issue every cycle, and results appear in matching cycles +4.
- Issue 3 words back-to-back, flush at cycle 2 → no res_valid strobe ever appears for those words; inflight reads 0 from cycle 3; a new issue at cycle 3 returns at cycle 7.
- rst_n pulled low asynchronously mid-cycle with 2 words in flight → all outputs are 0 immediately; after release the RR pointer is at data and no stale strobes appear.
